// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle controller sitting in front of a 4-bit combinational ALU.
//   Keeps a small register file, accepts register-to-register instructions
//   over a valid/ready handshake, presents registered operands to the ALU,
//   captures the ALU outputs and writes the result and flags back.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   instr_valid/instr_ready       instruction handshake
//   instr_op/rd/rs1/rs2           instruction fields (opcode, dest, sources)
//   wr_en/wr_addr/wr_data         direct register preload (honoured in IDLE only)
//   rd_addr/rd_data               combinational debug read of the register file
//   alu_a/alu_b/alu_op            registered operands and opcode to the ALU
//   alu_result/alu_carry/alu_zero ALU outputs
//   done                          one-cycle pulse in the cycle after writeback
//   res_data                      last written-back result
//   carry_flag                    sticky carry, updated by add/sub only
//   zero_flag                     zero flag of the last result
//   dbg_state                     current FSM state (0 IDLE, 1 EXEC, 2 WB)
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; the source holds its fields stable until then.

module alu_sequencer #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [2:0]                  instr_op,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rd,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] instr_rs2,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [2:0]                  alu_op,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        alu_carry,
    input  logic                        alu_zero,
    output logic                        done,
    output logic [DATA_W-1:0]           res_data,
    output logic                        carry_flag,
    output logic                        zero_flag,
    output logic [1:0]                  dbg_state
);

    localparam int AW = $clog2(NUM_REGS);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [2:0]        alu_op_q;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] res_cap_q;
    logic              carry_cap_q;
    logic              zero_cap_q;
    logic              done_q;
    logic [DATA_W-1:0] res_data_q;
    logic              carry_flag_q;
    logic              zero_flag_q;

    // A preload in IDLE takes priority, so the instruction waits a cycle.
    assign instr_ready = (state_q == ST_IDLE) && !wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rd_q         <= '0;
            res_cap_q    <= '0;
            carry_cap_q  <= 1'b0;
            zero_cap_q   <= 1'b0;
            done_q       <= 1'b0;
            res_data_q   <= '0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_en) begin
                        regs_q[wr_addr] <= wr_data;
                    end else if (instr_valid) begin
                        // Operands are read here, after any writeback edge,
                        // so a dependent instruction sees the new value.
                        alu_a_q  <= regs_q[instr_rs1];
                        alu_b_q  <= regs_q[instr_rs2];
                        alu_op_q <= instr_op;
                        rd_q     <= instr_rd;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_cap_q   <= alu_result;
                    carry_cap_q <= alu_carry;
                    zero_cap_q  <= alu_zero;
                    state_q     <= ST_WB;
                end
                ST_WB: begin
                    regs_q[rd_q] <= res_cap_q;
                    res_data_q   <= res_cap_q;
                    zero_flag_q  <= zero_cap_q;
                    // Carry is sticky across logic and shift operations.
                    if (alu_op_q == OP_ADD || alu_op_q == OP_SUB) begin
                        carry_flag_q <= carry_cap_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_data    = regs_q[rd_addr];
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign done       = done_q;
    assign res_data   = res_data_q;
    assign carry_flag = carry_flag_q;
    assign zero_flag  = zero_flag_q;
    assign dbg_state  = state_q;

endmodule
